// File: rtl/GLOBAL_PARAM.sv
// Shared FC datapath parameters, bit-width helper and loader state encoding.
package GLOBAL_PARAM;

  localparam int IDX_W = 8;

  // Bits needed to hold the values 0 .. n-1 (at least 1).
  function automatic int bw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LAUNCH,
    START,
    WAIT,
    DRAIN
  } fc_ldr_state_t;

endpackage

// File: rtl/fc_idx_loader.sv
// Loads a sparse index stream into the index buffer, launches fc_agu over it
// and reports done once the AGU pass and its pipeline have drained.
//
// state  | meaning
// IDLE   | waiting for conf_start
// LOAD   | accepting index beats, one registered buffer write per beat
// LAUNCH | final write on the buffer port, AGU config being prepared
// START  | agu_start pulse, agu_idx_cnt / agu_is_new presented
// WAIT   | AGU read pass in flight (first cycle ignores stale agu_done)
// DRAIN  | counting down the AGU pipeline before done
module fc_idx_loader
  import GLOBAL_PARAM::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DRAIN_CYC = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               conf_start,
  input  logic               conf_is_new,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic [2*IDX_W-1:0] in_idx,
  input  logic               in_last,
  output logic               idx_wr_en,
  output logic [ADDR_W-1:0]  idx_wr_addr,
  output logic [2*IDX_W-1:0] idx_wr_data,
  output logic               agu_start,
  output logic [7:0]         agu_idx_cnt,
  output logic               agu_is_new,
  input  logic               agu_done,
  output logic               busy,
  output logic               done,
  output logic               err_overflow
);

  localparam int CNT_W = bw(DRAIN_CYC);
  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  fc_ldr_state_t     state;
  logic [ADDR_W-1:0] ptr;
  logic              full;
  logic              is_new_q;
  logic              wait_1st;
  logic [CNT_W-1:0]  drain_cnt;

  assign in_rdy = (state == LOAD);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      full         <= 1'b0;
      is_new_q     <= 1'b0;
      wait_1st     <= 1'b0;
      drain_cnt    <= '0;
      idx_wr_en    <= 1'b0;
      idx_wr_addr  <= '0;
      idx_wr_data  <= '0;
      agu_start    <= 1'b0;
      agu_idx_cnt  <= '0;
      agu_is_new   <= 1'b0;
      done         <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      idx_wr_en <= 1'b0;
      agu_start <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (conf_start) begin
            is_new_q     <= conf_is_new;
            ptr          <= '0;
            full         <= 1'b0;
            err_overflow <= 1'b0;
            state        <= LOAD;
          end
        end
        LOAD: begin
          if (in_vld) begin
            // Once every entry is written, further beats are consumed and dropped.
            if (full) begin
              err_overflow <= 1'b1;
            end else begin
              idx_wr_en   <= 1'b1;
              idx_wr_addr <= ptr;
              idx_wr_data <= in_idx;
              if (ptr == PTR_MAX) full <= 1'b1;
              else                ptr  <= ptr + 1'b1;
            end
            if (in_last) state <= LAUNCH;
          end
        end
        LAUNCH: begin
          agu_start   <= 1'b1;
          agu_idx_cnt <= 8'(full ? ptr : ptr - 1'b1);
          agu_is_new  <= is_new_q;
          state       <= START;
        end
        START: begin
          wait_1st <= 1'b1;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_1st) begin
            wait_1st <= 1'b0;
          end else if (agu_done) begin
            drain_cnt <= CNT_W'(DRAIN_CYC - 1);
            done      <= (DRAIN_CYC == 1);
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          // done is registered one step early so it coincides with count 0.
          if (drain_cnt == '0) begin
            state <= IDLE;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
            done      <= (drain_cnt == CNT_W'(1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fc_idx_loader.md
Name: fc_idx_loader

Overview:
- Write-side counterpart of the FC address generator (fc_agu).
- Accepts a valid/ready stream of sparse index pairs {idx_y, idx_x}, writes them into the index buffer at consecutive addresses, then launches fc_agu with the matching entry count and is_new flag.
- Waits for the AGU read pass to finish, then waits for its fixed pipeline to drain before reporting done.
- Sits between the DDR/DMA index stream and the index buffer write port, one instance per FC PE group.

Parameters:
- ADDR_W, 8, index buffer address width; depth = 2^ADDR_W entries.
- DRAIN_CYC, 11, cycles to wait after agu_done before done (AGU pipeline depth plus 1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- conf_start  in  1  one-cycle pulse; begins a load/launch job
- conf_is_new  in  1  sampled on conf_start; forwarded as agu_is_new
- in_vld  in  1  index stream valid
- in_rdy  out  1  index stream ready
- in_idx  in  2*IDX_W  {idx_y, idx_x}
- in_last  in  1  marks the final pair of the job
- idx_wr_en  out  1  index buffer write enable
- idx_wr_addr  out  ADDR_W  index buffer write address
- idx_wr_data  out  2*IDX_W  index buffer write data
- agu_start  out  1  one-cycle start pulse to fc_agu
- agu_idx_cnt  out  8  address of the last written entry (entries−1)
- agu_is_new  out  1  to fc_agu conf_is_new
- agu_done  in  1  fc_agu done (1 while idle, drops the cycle after start)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job completion
- err_overflow  out  1  sticky; cleared on the next accepted conf_start

Behaviour:
- Reset: state IDLE. in_rdy, idx_wr_en, agu_start, busy, done and err_overflow are 0. idx_wr_addr, idx_wr_data, agu_idx_cnt and agu_is_new are 0. Write pointer is 0.
- Reset mid-job aborts immediately with no further writes or pulses; fc_agu is reset by the same rst.
- Transfer rule: a beat transfers when in_vld && in_rdy. in_rdy = (state == LOAD) only.
- IDLE: on conf_start, latch conf_is_new, clear the pointer and err_overflow, go to LOAD. conf_start is ignored in all other states.
- LOAD: accepts one beat per cycle.
  - Write is registered: a beat at cycle t gives idx_wr_en=1 at t+1, with addr = pointer and data = in_idx; the pointer then increments.
  - On the beat with in_last: go to LAUNCH.
- Overflow: beats arriving after 2^ADDR_W entries are written are accepted but not written. err_overflow is set at t+1 and the pointer saturates at 2^ADDR_W−1. Loading continues until in_last.
- LAUNCH (1 cycle, same cycle as the final write): go to START.
- START: agu_start=1 for one cycle.
  - agu_idx_cnt = pointer−1 (last written address), zero-extended or truncated to 8 bits.
  - agu_is_new = latched flag.
  - Go to WAIT.
- agu_idx_cnt and agu_is_new hold stable from START until the next job's START.
- WAIT: ignore agu_done in the first WAIT cycle, because fc_agu done is still high then. From the second cycle on, agu_done=1 → go to DRAIN with the counter loaded to DRAIN_CYC−1.
- DRAIN: decrement each cycle; at 0, done=1 for one cycle and go to IDLE. A new conf_start is accepted from the cycle after done.
- Single-beat job (in_last on the first beat): 1 entry written, agu_idx_cnt=0.
- Minimum latency: last beat at t → agu_start at t+2.

Decomposition:
- Shared package GLOBAL_PARAM supplies IDX_W and bw().
- Add the state enum fc_ldr_state_t {IDLE, LOAD, LAUNCH, START, WAIT, DRAIN} to that package for reuse by the FC top-level monitor.
- No sub-module: the FSM, pointer and drain counter are inline, about 180 lines.

Test Plan:
- conf_start(is_new=1), then 5 back-to-back beats with last on the 5th → writes at addr 0..4 with matching data; agu_start 2 cycles after the last beat; agu_idx_cnt=4; agu_is_new=1.
- Same 5 beats with in_vld toggling every other cycle → identical writes; no write during gaps; in_rdy stays high throughout LOAD.
- Single beat with in_last → one write at addr 0, agu_idx_cnt=0, then done.
- ADDR_W=4, 20 beats → addrs 0..15 written and 4 beats dropped; err_overflow=1; agu_idx_cnt=15. Next conf_start clears the flag.
- Model agu_done: stays 1 in the start cycle, drops, returns 7 cycles later → done asserts exactly DRAIN_CYC=11 cycles after agu_done returns high; conf_start pulses during WAIT are ignored.
- rst asserted during LOAD after 3 beats → next cycle all outputs 0, state IDLE; a new job restarts at addr 0.
